// File: rtl/ibex_hpm_ctrl.sv
// HPM counter control: event masks, inhibit, counter write pulses and CSR reads.
// Optional overflow flags and interrupt are built when IBEX_HPM_OVF_IRQ_EN is defined.
module ibex_hpm_ctrl #(
    parameter int unsigned NumCounters  = 4,
    parameter int unsigned NumEvents    = 16,
    parameter int unsigned CounterWidth = 40
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumEvents-1:0]        event_i,
    input  logic                        csr_we_i,
    input  logic                        csr_re_i,
    input  logic [11:0]                 csr_addr_i,
    input  logic [31:0]                 csr_wdata_i,
    output logic [31:0]                 csr_rdata_o,
    output logic                        csr_rvalid_o,
    output logic                        csr_err_o,
    input  logic [64*NumCounters-1:0]   cnt_val_i,
    output logic [NumCounters-1:0]      cnt_inc_o,
    output logic [NumCounters-1:0]      cnt_we_o,
    output logic [NumCounters-1:0]      cnt_weh_o,
    output logic [31:0]                 cnt_wdata_o,
    output logic                        ovf_irq_o
);

    localparam logic [11:0] AddrInhibit   = 12'h320;
    localparam logic [11:0] AddrEventBase = 12'h323;
    localparam logic [11:0] AddrCntBase   = 12'hB03;
    localparam logic [11:0] AddrCntHBase  = 12'hB83;
    localparam logic [11:0] AddrOvf       = 12'hDA0;

    logic [NumEvents-1:0]   event_q;
    logic [NumEvents-1:0]   mhpmevent_q [NumCounters];
    logic [NumEvents-1:0]   mhpmevent_d [NumCounters];
    logic [NumCounters-1:0] inhibit_q, inhibit_d;
    logic [NumCounters-1:0] cnt_we_q, cnt_we_d;
    logic [NumCounters-1:0] cnt_weh_q, cnt_weh_d;
    logic [31:0]            cnt_wdata_q, cnt_wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   rvalid_q;
    logic                   err_q, err_d;

    logic                   inhibit_hit, ovf_hit, addr_valid;
    logic [NumCounters-1:0] event_hit, cnt_hit, cnth_hit;
    logic [31:0]            rd_val, inhibit_rd, ovf_rd;

    // NOTE: every signal gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        inhibit_hit = (csr_addr_i == AddrInhibit);
        ovf_hit     = (csr_addr_i == AddrOvf);
        event_hit   = '0;
        cnt_hit     = '0;
        cnth_hit    = '0;
        for (int i = 0; i < NumCounters; i++) begin
            event_hit[i] = (csr_addr_i == AddrEventBase + 12'(i));
            cnt_hit[i]   = (csr_addr_i == AddrCntBase + 12'(i));
            cnth_hit[i]  = (csr_addr_i == AddrCntHBase + 12'(i));
        end
        addr_valid = inhibit_hit | ovf_hit | (|event_hit) | (|cnt_hit) | (|cnth_hit);
    end

    assign inhibit_rd = 32'(inhibit_q) << 3;

    // Read data comes from current register state, so a same-cycle write returns the old value.
    always_comb begin
        rd_val = '0;
        if (inhibit_hit) rd_val = inhibit_rd;
        if (ovf_hit)     rd_val = ovf_rd;
        for (int i = 0; i < NumCounters; i++) begin
            if (event_hit[i]) rd_val = 32'(mhpmevent_q[i]);
            if (cnt_hit[i])   rd_val = cnt_val_i[64*i +: 32];
            if (cnth_hit[i])  rd_val = cnt_val_i[64*i+32 +: 32];
        end
    end

    always_comb begin
        for (int i = 0; i < NumCounters; i++) begin
            mhpmevent_d[i] = (csr_we_i && event_hit[i]) ? csr_wdata_i[NumEvents-1:0] : mhpmevent_q[i];
        end
        inhibit_d   = (csr_we_i && inhibit_hit) ? csr_wdata_i[3 +: NumCounters] : inhibit_q;
        cnt_we_d    = {NumCounters{csr_we_i}} & cnt_hit;
        cnt_weh_d   = {NumCounters{csr_we_i}} & cnth_hit;
        cnt_wdata_d = ((|cnt_we_d) || (|cnt_weh_d)) ? csr_wdata_i : '0;
        rdata_d     = csr_re_i ? rd_val : '0;
        err_d       = (csr_re_i || csr_we_i) && !addr_valid;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            event_q     <= '0;
            // NOTE: the mask array is reset so no event counts before software programs it.
            for (int i = 0; i < NumCounters; i++) mhpmevent_q[i] <= '0;
            inhibit_q   <= '1;
            cnt_we_q    <= '0;
            cnt_weh_q   <= '0;
            cnt_wdata_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            event_q     <= event_i;
            for (int i = 0; i < NumCounters; i++) mhpmevent_q[i] <= mhpmevent_d[i];
            inhibit_q   <= inhibit_d;
            cnt_we_q    <= cnt_we_d;
            cnt_weh_q   <= cnt_weh_d;
            cnt_wdata_q <= cnt_wdata_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= csr_re_i;
            err_q       <= err_d;
        end
    end

    // Increments are suppressed in the cycle the core is loading the counter.
    always_comb begin
        cnt_inc_o = '0;
        for (int i = 0; i < NumCounters; i++) begin
            cnt_inc_o[i] = (|(event_q & mhpmevent_q[i])) & ~inhibit_q[i] & ~cnt_we_q[i] & ~cnt_weh_q[i];
        end
    end

`ifdef IBEX_HPM_OVF_IRQ_EN
    logic [NumCounters-1:0] ovf_q, ovf_d, ovf_set, ovf_clr;
    logic                   ovf_irq_q;

    // A flag sets when an increment lands on an all-ones counter; set wins over a W1C clear.
    always_comb begin
        ovf_set = '0;
        for (int i = 0; i < NumCounters; i++) begin
            ovf_set[i] = cnt_inc_o[i] & (&cnt_val_i[64*i +: CounterWidth]);
        end
        ovf_clr = (csr_we_i && ovf_hit) ? csr_wdata_i[3 +: NumCounters] : '0;
        ovf_d   = (ovf_q & ~ovf_clr) | ovf_set;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q     <= '0;
            ovf_irq_q <= 1'b0;
        end else begin
            ovf_q     <= ovf_d;
            ovf_irq_q <= |ovf_d;
        end
    end

    assign ovf_rd    = 32'(ovf_q) << 3;
    assign ovf_irq_o = ovf_irq_q;
`else
    assign ovf_rd    = '0;
    assign ovf_irq_o = 1'b0;
`endif

    assign csr_rdata_o  = rdata_q;
    assign csr_rvalid_o = rvalid_q;
    assign csr_err_o    = err_q;
    assign cnt_we_o     = cnt_we_q;
    assign cnt_weh_o    = cnt_weh_q;
    assign cnt_wdata_o  = cnt_wdata_q;

endmodule

// File: tb/tb_ibex_hpm_ctrl.sv
// Self-checking bench for ibex_hpm_ctrl (2 counters, 16 events, 40-bit counters)
// against a cycle-level behavioural model; honours IBEX_HPM_OVF_IRQ_EN.
module tb_ibex_hpm_ctrl;

    localparam int NC = 2;
    localparam int NE = 16;
    localparam int CW = 40;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NE-1:0]     event_i;
    logic              csr_we_i, csr_re_i;
    logic [11:0]       csr_addr_i;
    logic [31:0]       csr_wdata_i;
    logic [31:0]       csr_rdata_o;
    logic              csr_rvalid_o, csr_err_o;
    logic [64*NC-1:0]  cnt_val_i;
    logic [NC-1:0]     cnt_inc_o, cnt_we_o, cnt_weh_o;
    logic [31:0]       cnt_wdata_o;
    logic              ovf_irq_o;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state
    logic [NE-1:0] m_mask [NC];
    logic [NC-1:0] m_inh, m_ovf;
    logic [NC-1:0] e_inc, e_we, e_weh;
    logic [31:0]   e_wdata, e_rdata;
    logic          e_rvalid, e_err, e_irq;

    ibex_hpm_ctrl #(.NumCounters(NC), .NumEvents(NE), .CounterWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .event_i(event_i),
        .csr_we_i(csr_we_i), .csr_re_i(csr_re_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
        .csr_rvalid_o(csr_rvalid_o), .csr_err_o(csr_err_o),
        .cnt_val_i(cnt_val_i), .cnt_inc_o(cnt_inc_o), .cnt_we_o(cnt_we_o),
        .cnt_weh_o(cnt_weh_o), .cnt_wdata_o(cnt_wdata_o), .ovf_irq_o(ovf_irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a, output logic valid);
        int k;
        logic [31:0] r;
        k = int'(a);
        r = '0;
        valid = 1'b1;
        if (k == 'h320) begin
            for (int i = 0; i < NC; i++) r[3+i] = m_inh[i];
        end else if (k >= 'h323 && k < 'h323 + NC) begin
            r = 32'(m_mask[k-'h323]);
        end else if (k >= 'hB03 && k < 'hB03 + NC) begin
            r = cnt_val_i[64*(k-'hB03) +: 32];
        end else if (k >= 'hB83 && k < 'hB83 + NC) begin
            r = cnt_val_i[64*(k-'hB83)+32 +: 32];
        end else if (k == 'hDA0) begin
            for (int i = 0; i < NC; i++) r[3+i] = m_ovf[i];
        end else begin
            valid = 1'b0;
        end
        return r;
    endfunction

    // Apply one clock edge of the specified behaviour to the model.
    task automatic model_step();
        logic          valid;
        logic [31:0]   rv;
        logic [NC-1:0] set, clr;
        int            k;
        if (rst_i) begin
            for (int i = 0; i < NC; i++) m_mask[i] = '0;
            m_inh = '1; m_ovf = '0;
            e_inc = '0; e_we = '0; e_weh = '0; e_wdata = '0; e_rdata = '0;
            e_rvalid = 1'b0; e_err = 1'b0; e_irq = 1'b0;
            return;
        end
        rv       = model_read(csr_addr_i, valid);
        e_rvalid = csr_re_i;
        e_err    = (csr_re_i || csr_we_i) && !valid;
        e_rdata  = csr_re_i ? rv : 32'h0;
        k        = int'(csr_addr_i);
        set = '0; clr = '0;
        for (int i = 0; i < NC; i++) begin
`ifdef IBEX_HPM_OVF_IRQ_EN
            set[i] = e_inc[i] && (cnt_val_i[64*i +: CW] == {CW{1'b1}});
            clr[i] = csr_we_i && (k == 'hDA0) && csr_wdata_i[3+i];
`endif
            e_we[i]  = csr_we_i && (k == 'hB03 + i);
            e_weh[i] = csr_we_i && (k == 'hB83 + i);
        end
        e_wdata = (e_we != 0 || e_weh != 0) ? csr_wdata_i : 32'h0;
        if (csr_we_i && k == 'h320)
            for (int i = 0; i < NC; i++) m_inh[i] = csr_wdata_i[3+i];
        if (csr_we_i && k >= 'h323 && k < 'h323 + NC)
            m_mask[k-'h323] = csr_wdata_i[NE-1:0];
        m_ovf = (m_ovf & ~clr) | set;
        e_irq = (m_ovf != 0);
        for (int i = 0; i < NC; i++)
            e_inc[i] = ((event_i & m_mask[i]) != 0) && !m_inh[i] && !e_we[i] && !e_weh[i];
    endtask

    task automatic compare_all();
        check("cnt_inc", 64'(cnt_inc_o), 64'(e_inc));
        check("cnt_we", 64'(cnt_we_o), 64'(e_we));
        check("cnt_weh", 64'(cnt_weh_o), 64'(e_weh));
        if (e_we != 0 || e_weh != 0) check("cnt_wdata", 64'(cnt_wdata_o), 64'(e_wdata));
        check("rvalid", 64'(csr_rvalid_o), 64'(e_rvalid));
        check("err", 64'(csr_err_o), 64'(e_err));
        check("rdata", 64'(csr_rdata_o), 64'(e_rdata));
        check("ovf_irq", 64'(ovf_irq_o), 64'(e_irq));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle_csr();
        csr_we_i = 1'b0; csr_re_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = d;
        step();
        idle_csr();
    endtask

    logic [11:0] addr_tab [14];

    initial begin
        addr_tab = '{12'h320, 12'h321, 12'h323, 12'h324, 12'h325, 12'hB03, 12'hB04,
                     12'hB05, 12'hB83, 12'hB84, 12'hB85, 12'hDA0, 12'h000, 12'hDA1};
        rst_i = 1'b1; event_i = '0; cnt_val_i = '0;
        idle_csr();
        @(negedge clk);
        step(); step();
        rst_i = 1'b0;

        // Inhibit reads back all-ones for the served bits after reset
        csr_re_i = 1'b1; csr_addr_i = 12'h320;
        step();
        check("rst_inhibit_rd", 64'(csr_rdata_o), 64'h18);
        idle_csr();

        // Event enabled but still inhibited: no increments
        csr_write(12'h323, 32'h0004);
        event_i = 16'h0004;
        step(); step();
        check("inhibited_inc", 64'(cnt_inc_o[0]), 64'd0);
        csr_write(12'h320, 32'h0);
        check("resume_inc", 64'(cnt_inc_o[0]), 64'd1);
        event_i = '0;
        step();

        // Single event pulse gives a single increment one cycle later
        event_i = 16'h0004;
        step();
        check("pulse_inc", 64'(cnt_inc_o[0]), 64'd1);
        event_i = '0;
        step();
        check("pulse_inc_end", 64'(cnt_inc_o[0]), 64'd0);

        // Counter write drops the coinciding increment
        event_i = 16'h0004;
        step();
        csr_write(12'hB03, 32'h1234);
        check("wr_we", 64'(cnt_we_o[0]), 64'd1);
        check("wr_data", 64'(cnt_wdata_o), 64'h1234);
        check("wr_inc_drop", 64'(cnt_inc_o[0]), 64'd0);
        step();
        check("wr_inc_back", 64'(cnt_inc_o[0]), 64'd1);
        event_i = '0;

        // High-word read of counter 4 and an out-of-range counter read
        cnt_val_i = {$urandom, $urandom, $urandom, $urandom};
        csr_re_i = 1'b1; csr_addr_i = 12'hB84;
        step();
        check("rd_b84_data", 64'(csr_rdata_o), 64'(cnt_val_i[127:96]));
        check("rd_b84_err", 64'(csr_err_o), 64'd0);
        csr_addr_i = 12'hB05;
        step();
        check("rd_b05_err", 64'(csr_err_o), 64'd1);
        check("rd_b05_data", 64'(csr_rdata_o), 64'd0);
        idle_csr();

        // Overflow on an all-ones 40-bit counter, then W1C clear
        cnt_val_i = '0;
        cnt_val_i[CW-1:0] = {CW{1'b1}};
        event_i = 16'h0004;
        step();
        event_i = '0;
        step();
`ifdef IBEX_HPM_OVF_IRQ_EN
        check("ovf_irq_set", 64'(ovf_irq_o), 64'd1);
`else
        check("ovf_irq_off", 64'(ovf_irq_o), 64'd0);
`endif
        csr_write(12'hDA0, 32'h8);
        check("ovf_irq_clr", 64'(ovf_irq_o), 64'd0);

        // Reset arriving with a read and a counter write in flight
        csr_re_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = 12'hB03; csr_wdata_i = 32'hDEAD;
        rst_i = 1'b1;
        step();
        check("rst_rvalid", 64'(csr_rvalid_o), 64'd0);
        check("rst_we", 64'(cnt_we_o), 64'd0);
        rst_i = 1'b0;
        idle_csr();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            rst_i       = ($urandom_range(0, 99) == 0);
            event_i     = NE'($urandom);
            csr_we_i    = ($urandom_range(0, 2) == 0);
            csr_re_i    = ($urandom_range(0, 1) == 0);
            csr_addr_i  = addr_tab[$urandom_range(0, 13)];
            csr_wdata_i = $urandom;
            cnt_val_i   = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < NC; i++)
                if ($urandom_range(0, 3) == 0) cnt_val_i[64*i +: CW] = {CW{1'b1}};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
